pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/BasicTypes.sv | 11 +
 rtl/RvTypes.sv | 9 +
 rtl/pipeline_event_counter.sv | 40 ++++
 rtl/pipeline_hazard_controller.sv | 122 ++++++++++++
 4 files changed

// File: rtl/BasicTypes.sv
// BasicTypes: small enums and helpers shared by the pipeline control blocks.
package BasicTypes;

    // Hazard controller FSM: either passing instructions normally or
    // holding the flush line high while the front end is redirected.
    typedef enum logic {
        IDLE     = 1'b0,
        FLUSHING = 1'b1
    } PipelineControllerState;

endpackage

// File: rtl/RvTypes.sv
// RvTypes: RISC-V architectural types shared across the core.
// Provides addr_t, the width used for every program-counter value.
package RvTypes;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/pipeline_event_counter.sv
// pipeline_event_counter: one performance event counter for the hazard
// controller. It either saturates at all-ones or wraps around.
// The module exists only when RAFI_PIPELINE_PERF_COUNTER_EN is defined.
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
module pipeline_event_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: hold at all-ones when saturating, otherwise wrap on overflow.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (!(SATURATE && (&count_q))) begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register, cleared by reset regardless of a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: per-stage stall generation and flush/redirect
// sequencing for the in-order pipeline.
// Optional feature macro: RAFI_PIPELINE_PERF_COUNTER_EN adds the stallCycles
// and flushCount event counters (pipeline_event_counter instances).
module pipeline_hazard_controller
    import RvTypes::*;
    import BasicTypes::*;
#(
    parameter int FLUSH_CYCLES       = 1,
    parameter int PERF_COUNTER_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          exStallReq,
    input  logic                          maStallReq,
    input  logic                          flushReq,
    input  addr_t                         nextPc,
    output logic                          ifStall,
    output logic                          idStall,
    output logic                          rrStall,
    output logic                          exStall,
    output logic                          bypassStall,
    output logic                          flush,
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
    output logic [PERF_COUNTER_WIDTH-1:0] stallCycles,
    output logic [PERF_COUNTER_WIDTH-1:0] flushCount,
`endif
    output addr_t                         redirectPc
);

    // Reject out-of-range configurations when the design is elaborated.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : gBadFlushCycles
        $error("FLUSH_CYCLES must be within 1..15");
    end
    if (PERF_COUNTER_WIDTH < 1) begin : gBadPerfWidth
        $error("PERF_COUNTER_WIDTH must be at least 1");
    end

    // The remaining-cycle counter starts from FLUSH_CYCLES-1 so that the
    // flush line stays up for exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    PipelineControllerState state_q;
    PipelineControllerState state_d;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_d;
    addr_t                  redirect_q;
    addr_t                  redirect_d;

    // A flush from MA is only taken when MA itself is not stalled; a request
    // raised during a stall is dropped and re-presented by MA later.
    logic flushAccept;
    assign flushAccept = flushReq & ~maStallReq;

    // State register: reset wins over any in-progress or same-cycle flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
        end
    end

    // Next state: an accepted flush always (re)starts the sequence with the
    // newest target; otherwise count down and drop back to IDLE at zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = redirect_q;
        if (flushAccept) begin
            state_d    = FLUSHING;
            cnt_d      = FLUSH_LOAD;
            redirect_d = nextPc;
        end else if (state_q == FLUSHING) begin
            if (cnt_q == 4'd0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // Outputs: flush follows the registered state; stalls are combinational.
    // Flush overrides stalling, but EX must still hold while MA is stalled.
    always_comb begin
        flush       = (state_q == FLUSHING);
        exStall     = maStallReq;
        ifStall     = ~flush & (maStallReq | exStallReq);
        idStall     = ~flush & (maStallReq | exStallReq);
        rrStall     = ~flush & (maStallReq | exStallReq);
        bypassStall = ~flush & (maStallReq | exStallReq);
    end

    assign redirectPc = redirect_q;

`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
    pipeline_event_counter #(
        .WIDTH    (PERF_COUNTER_WIDTH),
        .SATURATE (1'b1)
    ) uStallCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifStall),
        .count (stallCycles)
    );

    pipeline_event_counter #(
        .WIDTH    (PERF_COUNTER_WIDTH),
        .SATURATE (1'b0)
    ) uFlushCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (flushAccept),
        .count (flushCount)
    );
`endif

endmodule
